multicycle_ctrl: RTL

//  Multicycle RV32I control FSM (lw, sw, R-type, I-type ALU, jal, beq) sequencing a shared-memory datapath.

---
 rtl/ctrl_pkg.sv | 41 ++++
 rtl/multicycle_ctrl_alu_dec.sv | 27 ++
 rtl/multicycle_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// The TRAP state exists only when MULTICYCLE_CTRL_TRAP_EN is defined.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_JAL, S_ALUWB, S_BEQ
`ifdef MULTICYCLE_CTRL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                           ALU_OR  = 3'b011, ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10;
    localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE: return IMM_S;
            OP_BEQ:   return IMM_B;
            OP_JAL:   return IMM_J;
            default:  return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU decoder: ALUOp plus funct fields to ALUControl.
import ctrl_pkg::*;

module alu_dec (
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7,
    output logic [2:0] alucontrol
);
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = (op5 & funct7) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with memory handshake and wait timeout.
// Define MULTICYCLE_CTRL_TRAP_EN to trap on illegal opcodes instead of skipping them.
import ctrl_pkg::*;

module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       mem_timeout,
    output logic       illegal_instr
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] wcnt;
    logic          waiting, timeout;
    logic          pcupdate, branch;
    logic [1:0]    aluop;
    logic [2:0]    alu_ctl;

    assign waiting = (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE) && !mem_ready;
    assign timeout = waiting && (TIMEOUT_CYCLES != 0) && (int'(wcnt) == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || timeout)
                wcnt <= '0;
            else if (waiting && TIMEOUT_CYCLES != 0)
                wcnt <= wcnt + 1'b1;
        end
    end

`ifdef MULTICYCLE_CTRL_TRAP_EN
    logic ill_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     ill_q <= 1'b0;
        else if (state_nxt == S_TRAP) ill_q <= 1'b1;
    end
    assign illegal_instr = ill_q & ~rst;
`else
    assign illegal_instr = 1'b0;
`endif

    alu_dec u_alu_dec (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7     (funct7),
        .alucontrol (alu_ctl)
    );
    assign ALUControl = rst ? ALU_ADD : alu_ctl;

    always_comb begin
        state_nxt   = state;
        mem_req     = 1'b0;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        aluop       = ALUOP_ADD;
        pcupdate    = 1'b0;
        branch      = 1'b0;
        mem_timeout = 1'b0;
        ImmSrc      = imm_src(op);
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    pcupdate  = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECUTER;
                    OP_ITYPE:          state_nxt = S_EXECUTEI;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_BEQ:            state_nxt = S_BEQ;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    default:           state_nxt = S_TRAP;
`else
                    default:           state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_nxt = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA   = SRCA_RS1;
                aluop     = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                aluop     = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pcupdate  = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_RS1;
                aluop     = ALUOP_SUB;
                branch    = 1'b1;
                state_nxt = S_FETCH;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_TRAP: state_nxt = S_TRAP;
`endif
            default: state_nxt = S_FETCH;
        endcase

        // An aborted access commits nothing; MemWrite is deliberately left as-is.
        if (timeout) begin
            mem_timeout = 1'b1;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            pcupdate    = 1'b0;
            branch      = 1'b0;
            state_nxt   = S_FETCH;
        end
        PCWrite = pcupdate | (branch & Zero);

        if (rst) begin
            mem_req     = 1'b0;
            PCWrite     = 1'b0;
            AdrSrc      = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            ResultSrc   = 2'b00;
            ALUSrcA     = 2'b00;
            ALUSrcB     = 2'b00;
            ImmSrc      = 2'b00;
            mem_timeout = 1'b0;
        end
    end
endmodule
